// File: rtl/sb_rx_deserializer_if.sv
// Sideband RX deserializer bus.
//   i_sb_bit        serial sideband data bit
//   i_sb_bit_valid  i_sb_bit holds a valid UI
//   i_flush         synchronous clear, drops any partial packet
//   o_deser_data    last completed packet (first bit received in bit 0)
//   o_de_ser_done   one-cycle strobe, o_deser_data updated
//   o_framing_error one-cycle strobe on gap violation or stall abort
//   o_busy          receiver is inside a packet or its trailing gap
//   o_deser_parity  XOR of the completed word (only with SB_RX_DESER_PARITY_EN)
// master: drives the lane side (the bench); slave: the deserializer.
interface sb_rx_deserializer_if #(
    parameter int unsigned DATA_W = 64
);
    logic              i_sb_bit;
    logic              i_sb_bit_valid;
    logic              i_flush;
    logic [DATA_W-1:0] o_deser_data;
    logic              o_de_ser_done;
    logic              o_framing_error;
    logic              o_busy;
`ifdef SB_RX_DESER_PARITY_EN
    logic              o_deser_parity;

    modport master (
        output i_sb_bit, i_sb_bit_valid, i_flush,
        input  o_deser_data, o_de_ser_done, o_framing_error, o_busy, o_deser_parity
    );
    modport slave (
        input  i_sb_bit, i_sb_bit_valid, i_flush,
        output o_deser_data, o_de_ser_done, o_framing_error, o_busy, o_deser_parity
    );
`else
    modport master (
        output i_sb_bit, i_sb_bit_valid, i_flush,
        input  o_deser_data, o_de_ser_done, o_framing_error, o_busy
    );
    modport slave (
        input  i_sb_bit, i_sb_bit_valid, i_flush,
        output o_deser_data, o_de_ser_done, o_framing_error, o_busy
    );
`endif
endinterface

// File: rtl/sb_rx_deserializer.sv
// Sideband receive deserializer: assembles DATA_W-bit packets from the serial
// sideband lane (first bit received lands in bit 0), strobes each completed
// word, and flags framing violations (short inter-packet gap, in-packet stall).
// Ports:
//   i_clk    sideband sampling clock
//   i_rst_n  asynchronous active-low reset
//   bus      sb_rx_deserializer_if.slave (lane inputs, flush, data/strobes/busy)
// Optional: define SB_RX_DESER_PARITY_EN to add bus.o_deser_parity, the XOR of
// the completed word, accumulated one bit per shifted UI.
module sb_rx_deserializer #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned GAP_MIN   = 32,
    parameter int unsigned STALL_MAX = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sb_rx_deserializer_if.slave   bus
);

    localparam int unsigned CNT_W   = $clog2(DATA_W);
    localparam int unsigned GAP_W   = $clog2(GAP_MIN + 1);
    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    // Holds the first DATA_W-1 bits; the final bit is merged straight into the output word.
    logic [DATA_W-2:0]   shift_q,     shift_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q,   gap_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;
    logic                busy_q,      busy_d;
`ifdef SB_RX_DESER_PARITY_EN
    logic                par_acc_q,   par_acc_d;
    logic                parity_q,    parity_d;
`endif

    // New bit enters at the top so the earliest bit drifts down to bit 0.
    logic [DATA_W-2:0]   shift_in;
    assign shift_in = {bus.i_sb_bit, shift_q[DATA_W-2:1]};

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        stall_cnt_d = stall_cnt_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef SB_RX_DESER_PARITY_EN
        par_acc_d   = par_acc_q;
        parity_d    = parity_q;
`endif

        if (bus.i_flush) begin
            // Flush wins over everything; a bit valid this cycle is dropped.
            state_d     = IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            gap_cnt_d   = '0;
            stall_cnt_d = '0;
`ifdef SB_RX_DESER_PARITY_EN
            par_acc_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_sb_bit_valid) begin
                        shift_d     = shift_in;
                        bit_cnt_d   = CNT_W'(1);
                        stall_cnt_d = '0;
                        state_d     = SHIFT;
`ifdef SB_RX_DESER_PARITY_EN
                        par_acc_d   = bus.i_sb_bit;
`endif
                    end
                end

                SHIFT: begin
                    if (bus.i_sb_bit_valid) begin
                        stall_cnt_d = '0;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            data_d    = {bus.i_sb_bit, shift_q};
                            done_d    = 1'b1;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            gap_cnt_d = '0;
                            state_d   = GAP;
`ifdef SB_RX_DESER_PARITY_EN
                            parity_d  = par_acc_q ^ bus.i_sb_bit;
                            par_acc_d = 1'b0;
`endif
                        end else begin
                            shift_d   = shift_in;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef SB_RX_DESER_PARITY_EN
                            par_acc_d = par_acc_q ^ bus.i_sb_bit;
`endif
                        end
                    end else if (stall_cnt_q >= STALL_W'(STALL_MAX - 1)) begin
                        // This idle cycle is the STALL_MAX-th in a row: abort the packet.
                        err_d       = 1'b1;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                        stall_cnt_d = '0;
                        state_d     = IDLE;
`ifdef SB_RX_DESER_PARITY_EN
                        par_acc_d   = 1'b0;
`endif
                    end else begin
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    end
                end

                GAP: begin
                    if (bus.i_sb_bit_valid) begin
                        // Gap too short: flag it, but keep the bit as the start of a new packet.
                        err_d       = 1'b1;
                        shift_d     = shift_in;
                        bit_cnt_d   = CNT_W'(1);
                        stall_cnt_d = '0;
                        state_d     = SHIFT;
`ifdef SB_RX_DESER_PARITY_EN
                        par_acc_d   = bus.i_sb_bit;
`endif
                    end else if (gap_cnt_q >= GAP_W'(GAP_MIN - 1)) begin
                        gap_cnt_d = GAP_W'(GAP_MIN);
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            stall_cnt_q <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SB_RX_DESER_PARITY_EN
            par_acc_q   <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
`ifdef SB_RX_DESER_PARITY_EN
            par_acc_q   <= par_acc_d;
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.o_deser_data    = data_q;
    assign bus.o_de_ser_done   = done_q;
    assign bus.o_framing_error = err_q;
    assign bus.o_busy          = busy_q;
`ifdef SB_RX_DESER_PARITY_EN
    assign bus.o_deser_parity  = parity_q;
`endif

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Bench for sb_rx_deserializer: directed packets, gaps, stalls, flushes and an
// async reset, checked every cycle against a packet-level model plus literals.
module tb_sb_rx_deserializer;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned GAP_MIN   = 32;
    localparam int unsigned STALL_MAX = 8;

    logic i_clk;
    logic i_rst_n;

    sb_rx_deserializer_if #(.DATA_W(DATA_W)) bus ();

    sb_rx_deserializer #(
        .DATA_W   (DATA_W),
        .GAP_MIN  (GAP_MIN),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    // mode 0: between packets, 1: collecting bits, 2: post-packet gap
    int          m_mode;
    int          m_cnt;    // bits collected so far
    int          m_idle;   // consecutive idle cycles in the current mode
    logic [63:0] m_word;   // bit i of the packet stored at index i
    logic [63:0] exp_data;
    logic        exp_done, exp_err, exp_busy;
`ifdef SB_RX_DESER_PARITY_EN
    logic        exp_parity;
`endif

    function automatic logic [63:0] full_word(input logic [63:0] w, input logic b);
        logic [63:0] r;
        r = w;
        r[DATA_W-1] = b;
        return r;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_mode <= 0; m_cnt <= 0; m_idle <= 0; m_word <= '0;
            exp_data <= '0; exp_done <= 1'b0; exp_err <= 1'b0; exp_busy <= 1'b0;
`ifdef SB_RX_DESER_PARITY_EN
            exp_parity <= 1'b0;
`endif
        end else begin
            exp_done <= 1'b0;
            exp_err  <= 1'b0;
            if (bus.i_flush) begin
                m_mode <= 0; m_cnt <= 0; m_idle <= 0; exp_busy <= 1'b0;
            end else if (m_mode == 0) begin
                if (bus.i_sb_bit_valid) begin
                    m_word <= 64'(bus.i_sb_bit); m_cnt <= 1; m_idle <= 0;
                    m_mode <= 1; exp_busy <= 1'b1;
                end
            end else if (m_mode == 1) begin
                if (bus.i_sb_bit_valid) begin
                    m_idle <= 0;
                    if (m_cnt == DATA_W - 1) begin
                        exp_data <= full_word(m_word, bus.i_sb_bit);
`ifdef SB_RX_DESER_PARITY_EN
                        exp_parity <= ^full_word(m_word, bus.i_sb_bit);
`endif
                        exp_done <= 1'b1; m_mode <= 2; m_cnt <= 0;
                    end else begin
                        m_word[m_cnt] <= bus.i_sb_bit;
                        m_cnt <= m_cnt + 1;
                    end
                end else if (m_idle + 1 >= STALL_MAX) begin
                    exp_err <= 1'b1; m_mode <= 0; m_cnt <= 0; m_idle <= 0; exp_busy <= 1'b0;
                end else begin
                    m_idle <= m_idle + 1;
                end
            end else begin
                if (bus.i_sb_bit_valid) begin
                    exp_err <= 1'b1; m_word <= 64'(bus.i_sb_bit); m_cnt <= 1;
                    m_idle <= 0; m_mode <= 1;
                end else if (m_idle + 1 >= GAP_MIN) begin
                    m_mode <= 0; exp_busy <= 1'b0;
                end else begin
                    m_idle <= m_idle + 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus strobe counting.
    always @(posedge i_clk) begin
        #1;
        if (i_rst_n) begin
            check("data",  bus.o_deser_data,           exp_data);
            check("done",  64'(bus.o_de_ser_done),     64'(exp_done));
            check("error", 64'(bus.o_framing_error),   64'(exp_err));
            check("busy",  64'(bus.o_busy),            64'(exp_busy));
`ifdef SB_RX_DESER_PARITY_EN
            check("parity", 64'(bus.o_deser_parity),   64'(exp_parity));
`endif
            if (bus.o_de_ser_done === 1'b1)   n_done++;
            if (bus.o_framing_error === 1'b1) n_err++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic b, input logic f);
        @(negedge i_clk);
        bus.i_sb_bit_valid = v;
        bus.i_sb_bit       = b;
        bus.i_flush        = f;
    endtask

    task automatic send(input logic [63:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive(1'b1, w[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge i_clk);
        #2;
    endtask

    int d0, e0;

    initial begin
        bus.i_sb_bit = 1'b0; bus.i_sb_bit_valid = 1'b0; bus.i_flush = 1'b0;
        i_rst_n = 1'b1;
        #1 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        check("rst_data",  bus.o_deser_data,         64'h0);
        check("rst_done",  64'(bus.o_de_ser_done),   64'h0);
        check("rst_error", 64'(bus.o_framing_error), 64'h0);
        check("rst_busy",  64'(bus.o_busy),          64'h0);
        @(negedge i_clk) i_rst_n = 1'b1;
        idle(2);

        // Single packet followed by a legal gap.
        d0 = n_done; e0 = n_err;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64);
        idle(32);
        settle();
        check("t1_data",  bus.o_deser_data, 64'hAAAA_AAAA_AAAA_AAAA);
        check("t1_busy",  64'(bus.o_busy),  64'h0);
        check("t1_ndone", 64'(n_done - d0), 64'd1);
        check("t1_nerr",  64'(n_err - e0),  64'd0);
`ifdef SB_RX_DESER_PARITY_EN
        check("t1_parity", 64'(bus.o_deser_parity), 64'h0);
`endif

        // Back-to-back with exactly the minimum gap.
        d0 = n_done; e0 = n_err;
        send(64'h0123_4567_89AB_CDEF, 64);
        idle(32);
        send(64'hFEDC_BA98_7654_3210, 64);
        idle(32);
        settle();
        check("t2_data",  bus.o_deser_data, 64'hFEDC_BA98_7654_3210);
        check("t2_ndone", 64'(n_done - d0), 64'd2);
        check("t2_nerr",  64'(n_err - e0),  64'd0);

        // Short gap: error on first bit of packet 2, packet 2 still delivered.
        d0 = n_done; e0 = n_err;
        send(64'hFEDC_BA98_7654_3210, 64);
        idle(20);
        send(64'h0123_4567_89AB_CDEF, 64);
        idle(32);
        settle();
        check("t3_data",  bus.o_deser_data, 64'h0123_4567_89AB_CDEF);
        check("t3_ndone", 64'(n_done - d0), 64'd2);
        check("t3_nerr",  64'(n_err - e0),  64'd1);

        // Stall abort after 30 bits, then a clean packet.
        d0 = n_done; e0 = n_err;
        send(64'h5555_5555_5555_5555, 30);
        idle(8);
        settle();
        check("t4_data",  bus.o_deser_data, 64'h0123_4567_89AB_CDEF);
        check("t4_busy",  64'(bus.o_busy),  64'h0);
        check("t4_ndone", 64'(n_done - d0), 64'd0);
        check("t4_nerr",  64'(n_err - e0),  64'd1);
        send(64'h0F0F_1234_F0F0_5678, 64);
        idle(32);
        settle();
        check("t4b_data", bus.o_deser_data, 64'h0F0F_1234_F0F0_5678);

        // Flush at bit 40, then a clean packet.
        d0 = n_done; e0 = n_err;
        send(64'hDEAD_BEEF_CAFE_F00D, 40);
        drive(1'b1, 1'b1, 1'b1);
        send(64'h8000_0000_0000_0001, 64);
        idle(32);
        settle();
        check("t5_data",  bus.o_deser_data, 64'h8000_0000_0000_0001);
        check("t5_ndone", 64'(n_done - d0), 64'd1);
        check("t5_nerr",  64'(n_err - e0),  64'd0);

        // Flush coinciding with the final bit: no done.
        d0 = n_done; e0 = n_err;
        send(64'h1111_2222_3333_4444, 63);
        drive(1'b1, 1'b1, 1'b1);
        idle(4);
        settle();
        check("t5b_data",  bus.o_deser_data, 64'h8000_0000_0000_0001);
        check("t5b_busy",  64'(bus.o_busy),  64'h0);
        check("t5b_ndone", 64'(n_done - d0), 64'd0);
        check("t5b_nerr",  64'(n_err - e0),  64'd0);

        // Async reset while the final bit is on the lane.
        d0 = n_done;
        send(64'h0000_0000_0000_0007, 63);
        drive(1'b1, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        check("t6_data",  bus.o_deser_data,         64'h0);
        check("t6_done",  64'(bus.o_de_ser_done),   64'h0);
        check("t6_error", 64'(bus.o_framing_error), 64'h0);
        check("t6_busy",  64'(bus.o_busy),          64'h0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge i_clk) i_rst_n = 1'b1;
        idle(5);
        settle();
        check("t6_ndone",    64'(n_done - d0),   64'd0);
        check("t6_data_hold", bus.o_deser_data,  64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_rx_deserializer.md
Name: sb_rx_deserializer

Overview:
Sideband receive deserializer that sits directly upstream of the sideband RX FSM. It samples the serial sideband lane one bit per valid UI and assembles 64-bit packets, first bit received in bit 0. It delivers each completed word with a one-cycle done strobe. It enforces packet framing: 64 UI of data, then a minimum idle gap, with a stall timeout inside a packet. Framing violations are flagged; the RX FSM performs pattern and parity decoding.

Parameters:
DATA_W, 64, packet width in bits (counter width = $clog2(DATA_W))
GAP_MIN, 32, minimum consecutive idle cycles (i_sb_bit_valid=0) required between packets
STALL_MAX, 8, maximum consecutive idle cycles tolerated inside a packet before abort

Ports:
i_clk  in  1  sideband sampling clock
i_rst_n  in  1  async active-low reset
i_sb_bit  in  1  serial sideband data bit
i_sb_bit_valid  in  1  high when i_sb_bit holds a valid UI (forwarded clock active)
i_flush  in  1  sync clear from LTSM (link state RESET); drops any partial packet
o_deser_data  out  DATA_W  last completed packet, held until next completion
o_de_ser_done  out  1  one-cycle strobe: o_deser_data updated this cycle
o_framing_error  out  1  one-cycle strobe on gap violation or stall abort
o_busy  out  1  high while in SHIFT or GAP state

Behaviour:
- Reset: i_rst_n is asynchronous and active-low; clock is i_clk. Reset sets every output to 0: o_deser_data=0, o_de_ser_done=0, o_framing_error=0, o_busy=0. Reset also clears the shift register and all counters and sets state=IDLE.
- All outputs are registered. o_de_ser_done and o_framing_error are single-cycle pulses.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - i_sb_bit_valid=1: capture bit as bit 0, bit_cnt=1, go to SHIFT.
  - i_sb_bit_valid=0: stay in IDLE.
- SHIFT:
  - Each cycle with i_sb_bit_valid=1: shift_reg <= {i_sb_bit, shift_reg[DATA_W-1:1]}, bit_cnt+1, stall_cnt=0.
  - The first bit received ends up in o_deser_data[0].
  - On the DATA_W-th valid bit, at the same edge:
    - o_deser_data <= full word including the current bit.
    - o_de_ser_done <= 1.
    - bit_cnt <= 0, gap_cnt <= 0, go to GAP.
    - Latency: done and data are visible in the cycle after the last bit is sampled.
  - i_sb_bit_valid=0 increments stall_cnt. When stall_cnt reaches STALL_MAX, the next edge pulses o_framing_error, discards the partial packet and goes to IDLE. o_deser_data is unchanged.
- GAP:
  - i_sb_bit_valid=0 increments gap_cnt (saturating). When gap_cnt reaches GAP_MIN, go to IDLE.
  - i_sb_bit_valid=1 before GAP_MIN is reached: pulse o_framing_error and resynchronise. The bit is taken as bit 0 of a new packet: bit_cnt=1, go to SHIFT.
- o_busy = (state != IDLE), registered alongside state.
- i_flush has priority over all other events. Next edge: state=IDLE, counters=0, o_de_ser_done=0, o_framing_error=0. o_deser_data is retained. A bit that is valid in the same cycle as the flush is dropped.
- If a DATA_W-th bit and i_flush coincide, no done pulse is issued.
- Back-to-back packets with exactly GAP_MIN idle cycles are legal. With GAP_MIN-1 idle cycles, a framing error is raised and the second packet is still assembled.
- All counters are unsigned and saturate. No counter wraps inside a state.

Optional Feature:
SB_RX_DESER_PARITY_EN
- Defined: adds output o_deser_parity (1 bit, reset 0).
  - It is the XOR of all DATA_W bits of the completed word.
  - It is accumulated incrementally per shifted bit, with no wide XOR tree.
  - It is registered and updated on the same edge as o_deser_data.
  - The RX FSM may use it for early parity checks.
- Not defined: the port, accumulator and logic are absent. Function is otherwise identical.

Test Plan:
- Send 64 valid bits of 0xAAAA_AAAA_AAAA_AAAA LSB-first, then 32 idle cycles -> o_deser_data=0xAAAA_AAAA_AAAA_AAAA, one o_de_ser_done pulse in the cycle after bit 63, no error, o_busy falls after the 32nd idle cycle.
- Two packets 0x0123_4567_89AB_CDEF and 0xFEDC_BA98_7654_3210 separated by exactly 32 idle cycles -> two done pulses carrying the correct words, o_framing_error never asserted.
- Same two packets separated by 20 idle cycles -> o_framing_error pulse on the first bit of packet 2, packet 2 still delivered correctly with done.
- Send 30 bits, then hold i_sb_bit_valid=0 for 8 cycles -> o_framing_error pulse, no done, o_deser_data keeps its previous value, state returns to IDLE; a following full packet is received correctly.
- Assert i_flush at bit 40 of a packet -> no done and no error; a subsequent clean 64-bit packet 0x8000_0000_0000_0001 is received with done.
- Assert async reset while in SHIFT at bit 63 -> all outputs 0 immediately, no done pulse after reset release (with SB_RX_DESER_PARITY_EN: parity of 0x0000_0000_0000_0007 = 1).
